// File: rtl/collision_arbiter_if.sv
// Lookup bus between the movement logic, the collision arbiter and the collision-map RAM.
// The arbiter uses the slave modport; requesters and the RAM model sit on the master side.
interface collision_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ*10-1:0] req_x;
   logic [N_REQ*10-1:0] req_y;
   logic [N_REQ-1:0]    ack;
   logic [N_REQ-1:0]    blk;
   logic                busy;
   logic [18:0]         mem_addr;
   logic                mem_dout;

   modport slave (
      input  req, req_x, req_y, mem_dout,
      output ack, blk, busy, mem_addr
   );

   modport master (
      output req, req_x, req_y, mem_dout,
      input  ack, blk, busy, mem_addr
   );
endinterface

// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one collision-map RAM (1 bit/pixel, row-major) among movers.
// One lookup in flight; result and a one-cycle ack come back RD_LAT+1 cycles after grant.
//
// state | meaning
// IDLE  | arbitrate; on a grant register mem_addr and load the latency timer
// WAIT  | timer counts down; at terminal count capture mem_dout and raise ack
// DONE  | ack visible for this single cycle; no arbitration
module collision_arbiter #(
   parameter int N_REQ  = 4,
   parameter int MAP_W  = 960,
   parameter int MAP_H  = 480,
   parameter int RD_LAT = 1
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   collision_arbiter_if.slave   bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] win_q, win_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             oob_q, oob_d;
   logic [18:0]      addr_q, addr_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [N_REQ-1:0] blk_q, blk_d;

   logic             grant_vld;
   logic [IDX_W-1:0] grant_idx;
   logic [9:0]       x_arr [N_REQ];
   logic [9:0]       y_arr [N_REQ];
   logic [9:0]       x_sel, y_sel;
   logic             oob_sel;
   logic [18:0]      addr_sel;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         x_arr[i] = bus.req_x[i*10 +: 10];
         y_arr[i] = bus.req_y[i*10 +: 10];
      end
   end

   // Search from ptr upward with wrap; first requester found wins.
   always_comb begin
      logic [IDX_W:0]   idx_ext;
      logic [IDX_W-1:0] idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx_ext   = '0;
      idx       = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_ext = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (idx_ext >= (IDX_W+1)'(N_REQ))
            idx_ext = idx_ext - (IDX_W+1)'(N_REQ);
         idx = idx_ext[IDX_W-1:0];
         if (!grant_vld && bus.req[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

   assign x_sel    = x_arr[grant_idx];
   assign y_sel    = y_arr[grant_idx];
   assign oob_sel  = (11'(x_sel) >= 11'(MAP_W)) || (11'(y_sel) >= 11'(MAP_H));
   assign addr_sel = 19'(y_sel) * 19'(MAP_W) + 19'(x_sel);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      oob_d   = oob_q;
      addr_d  = addr_q;
      ack_d   = '0;
      blk_d   = blk_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               win_d   = grant_idx;
               ptr_d   = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
               oob_d   = oob_sel;
               addr_d  = oob_sel ? '0 : addr_sel;
               cnt_d   = 2'(RD_LAT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            // Terminal count: this is the last cycle of RAM latency, mem_dout is valid now.
            if (cnt_q == 2'd1) begin
               blk_d[win_q] = oob_q | bus.mem_dout;
               ack_d[win_q] = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         oob_q   <= 1'b0;
         addr_q  <= '0;
         ack_q   <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         oob_q   <= oob_d;
         addr_q  <= addr_d;
         ack_q   <= ack_d;
         blk_q   <= blk_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.blk      = blk_q;
   assign bus.mem_addr = addr_q;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter: directed and random lookups checked against a lookup-level model,
// with one instance at read latency 1 and one at read latency 3.
module tb_collision_arbiter;
   localparam int N_REQ = 4;
   localparam int MAP_W = 960;
   localparam int MAP_H = 480;

   logic sys_clk = 1'b0;
   logic rst;
   always #5 sys_clk = ~sys_clk;

   collision_arbiter_if #(.N_REQ(N_REQ)) bus1 ();
   collision_arbiter_if #(.N_REQ(N_REQ)) bus3 ();

   collision_arbiter #(.N_REQ(N_REQ), .MAP_W(MAP_W), .MAP_H(MAP_H), .RD_LAT(1)) dut1 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus1)
   );

   collision_arbiter #(.N_REQ(N_REQ), .MAP_W(MAP_W), .MAP_H(MAP_H), .RD_LAT(3)) dut3 (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus3)
   );

   // Collision RAM model: latency 1 reads the registered address directly,
   // latency 3 delays the address by two further cycles.
   bit          ram_m [0:524287];
   logic [18:0] a3_d1, a3_d2;
   assign bus1.mem_dout = ram_m[bus1.mem_addr];
   always @(posedge sys_clk) begin
      a3_d1 <= bus3.mem_addr;
      a3_d2 <= a3_d1;
   end
   assign bus3.mem_dout = ram_m[a3_d2];

   int         tests_run    = 0;
   int         tests_failed = 0;
   int         ptr_m;
   logic [3:0] blk_m;
   logic [3:0] req_v;
   logic [9:0] xs [N_REQ];
   logic [9:0] ys [N_REQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive();
      bus1.req = req_v;
      for (int k = 0; k < N_REQ; k++) begin
         bus1.req_x[k*10 +: 10] = xs[k];
         bus1.req_y[k*10 +: 10] = ys[k];
      end
   endtask

   // Called in the IDLE cycle where req is sampled; returns in the following IDLE cycle.
   // drop: 0 keep req, 1 release the winner at its ack, 2 release everything at the ack.
   task automatic lookup(input int drop, input bit scramble);
      int          w;
      bit          oob;
      logic [18:0] ea;
      bit          eb;
      w = -1;
      for (int k = 0; k < N_REQ; k++)
         if (w < 0 && req_v[(ptr_m + k) % N_REQ]) w = (ptr_m + k) % N_REQ;
      if (w < 0) return;
      oob = (int'(xs[w]) >= MAP_W) || (int'(ys[w]) >= MAP_H);
      ea  = oob ? 19'd0 : 19'(int'(ys[w]) * MAP_W + int'(xs[w]));
      eb  = oob ? 1'b1 : ram_m[ea];

      tick();
      chk("addr_c1", bus1.mem_addr, ea);
      chk("busy_c1", bus1.busy, 1);
      chk("ack_c1", bus1.ack, 0);
      if (scramble) begin
         xs[w] = 10'($urandom_range(0, 1023));
         ys[w] = 10'($urandom_range(0, 1023));
         drive();
      end

      tick();
      blk_m[w] = eb;
      ptr_m    = (w + 1) % N_REQ;
      chk("ack_c2", bus1.ack, 32'(1 << w));
      chk("blk_c2", bus1.blk, blk_m);
      chk("busy_c2", bus1.busy, 1);
      if (drop == 1) req_v[w] = 1'b0;
      else if (drop == 2) req_v = '0;
      drive();

      tick();
      chk("ack_c3", bus1.ack, 0);
      chk("busy_c3", bus1.busy, 0);
      chk("blk_hold", bus1.blk, blk_m);
   endtask

   initial begin
      for (int i = 0; i < 524288; i++) ram_m[i] = 1'($urandom_range(0, 1));
      ram_m[0]      = 1'b0;
      ram_m[384244] = 1'b1;
      ram_m[460799] = 1'b0;
      ram_m[9620]   = 1'b1;
      ram_m[28840]  = 1'b0;

      rst = 1'b1;
      req_v = '0;
      for (int k = 0; k < N_REQ; k++) begin xs[k] = '0; ys[k] = '0; end
      drive();
      bus3.req = '0; bus3.req_x = '0; bus3.req_y = '0;
      ptr_m = 0; blk_m = '0;
      repeat (3) tick();
      chk("rst_ack", bus1.ack, 0);
      chk("rst_blk", bus1.blk, 0);
      chk("rst_busy", bus1.busy, 0);
      chk("rst_addr", bus1.mem_addr, 0);
      rst = 1'b0;
      tick();

      // Single request at (244,400).
      req_v = 4'b0001; xs[0] = 10'd244; ys[0] = 10'd400; drive();
      lookup(1, 1'b0);
      repeat (2) tick();
      chk("single_blk_hold", bus1.blk, 4'b0001);
      chk("idle_addr_hold", bus1.mem_addr, 384244);
      chk("idle_busy", bus1.busy, 0);

      // Round robin from a fresh pointer with all four requesting.
      rst = 1'b1; tick(); rst = 1'b0;
      ptr_m = 0; blk_m = '0;
      chk("rr_rst_blk", bus1.blk, 0);
      req_v = 4'b1111;
      for (int k = 0; k < N_REQ; k++) begin
         xs[k] = 10'(100 * k + 7); ys[k] = 10'(50 * k + 3);
      end
      drive();
      for (int n = 0; n < 5; n++) lookup((n == 4) ? 2 : 0, 1'b0);

      // Out of bounds on requester 2, both axes; then edge and origin addresses on 3.
      req_v = 4'b0100; xs[2] = 10'd960; ys[2] = 10'd0; drive();
      lookup(1, 1'b0);
      req_v = 4'b0100; xs[2] = 10'd0; ys[2] = 10'd480; drive();
      lookup(1, 1'b0);
      req_v = 4'b1000; xs[3] = 10'd959; ys[3] = 10'd479; drive();
      lookup(1, 1'b0);
      req_v = 4'b1000; xs[3] = 10'd0; ys[3] = 10'd0; drive();
      lookup(1, 1'b0);

      // Reset during cycle 1 of a lookup for requester 1.
      req_v = 4'b0010; xs[1] = 10'd100; ys[1] = 10'd50; drive();
      tick();
      chk("mid_addr_c1", bus1.mem_addr, 50 * MAP_W + 100);
      chk("mid_busy_c1", bus1.busy, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_ack", bus1.ack, 0);
      chk("mid_rst_busy", bus1.busy, 0);
      chk("mid_rst_addr", bus1.mem_addr, 0);
      chk("mid_rst_blk", bus1.blk, 0);
      rst = 1'b0;
      ptr_m = 0; blk_m = '0;
      lookup(1, 1'b0);

      // Random bursts: requesters drop req once acked.
      for (int r = 0; r < 12; r++) begin
         req_v = 4'($urandom_range(1, 15));
         for (int k = 0; k < N_REQ; k++) begin
            xs[k] = 10'($urandom_range(0, 1000));
            ys[k] = 10'($urandom_range(0, 500));
         end
         drive();
         for (int g = 0; g < N_REQ && req_v != 4'b0000; g++)
            lookup(1, 1'($urandom_range(0, 1)));
      end

      // Latency 3: coordinate change during WAIT must not affect the result.
      bus3.req_x[9:0] = 10'd20; bus3.req_y[9:0] = 10'd10; bus3.req = 4'b0001;
      tick();
      chk("l3_addr_c1", bus3.mem_addr, 9620);
      chk("l3_busy_c1", bus3.busy, 1);
      bus3.req_x[9:0] = 10'd40; bus3.req_y[9:0] = 10'd30;
      tick();
      chk("l3_ack_c2", bus3.ack, 0);
      chk("l3_addr_c2", bus3.mem_addr, 9620);
      tick();
      chk("l3_ack_c3", bus3.ack, 0);
      chk("l3_busy_c3", bus3.busy, 1);
      tick();
      chk("l3_ack_c4", bus3.ack, 4'b0001);
      chk("l3_blk_c4", bus3.blk, 4'b0001);
      bus3.req = '0;
      tick();
      chk("l3_ack_c5", bus3.ack, 0);
      chk("l3_busy_c5", bus3.busy, 0);
      bus3.req = 4'b0001;
      tick();
      chk("l3b_addr_c1", bus3.mem_addr, 28840);
      tick();
      tick();
      chk("l3b_ack_c3", bus3.ack, 0);
      tick();
      chk("l3b_ack_c4", bus3.ack, 4'b0001);
      chk("l3b_blk_c4", bus3.blk, 4'b0000);
      bus3.req = '0;
      tick();
      chk("l3b_busy_c5", bus3.busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
